fpu_f2i: RTL



---
 rtl/fpu_pkg.sv | 32 +++
 rtl/f2i_align.sv | 43 ++++
 rtl/fpu_f2i.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared IEEE754 field, class and opcode definitions for the FPU datapath
package fpu_pkg;

  localparam int SIGN_B = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  localparam logic [2:0] CLS_NORM = 3'd0;
  localparam logic [2:0] CLS_ZERO = 3'd1;
  localparam logic [2:0] CLS_TINY = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] F2I = 3'b010;

  // Stage-1 result: unbiased exponent is signed so TINY/NORM compares stay simple.
  typedef struct packed {
    logic              sign;
    logic              rnd;
    logic [2:0]        cls;
    logic signed [8:0] e;
    logic [23:0]       sig;
  } f2i_s1_t;

endpackage

// File: rtl/f2i_align.sv
// rtl/f2i_align.sv - combinational barrel shifter aligning the significand to a 32-bit integer
module f2i_align
  import fpu_pkg::*;
(
  input  logic [23:0]       i_sig,
  input  logic signed [8:0] i_exp,
  output logic [31:0]       o_int,
  output logic              o_guard,
  output logic              o_sticky,
  output logic              o_ovf,
  output logic              o_min
);

  logic [47:0] w_ext;
  logic [4:0]  w_rsh;
  logic [2:0]  w_lsh;

  always_comb begin
    o_int    = '0;
    o_guard  = 1'b0;
    o_sticky = 1'b0;
    o_ovf    = 1'b0;
    o_min    = 1'b0;
    w_ext    = '0;
    w_rsh    = '0;
    w_lsh    = '0;
    if (i_exp > 9'sd30) begin
      o_ovf = 1'b1;
      o_min = (i_exp == 9'sd31) && (i_sig == 24'h80_0000);
    end else if (i_exp > 9'sd23) begin
      w_lsh = 3'(i_exp - 9'sd23);
      o_int = {8'b0, i_sig} << w_lsh;
    end else begin
      // e=-1 shifts by 24: integer 0, guard is the hidden bit, sticky the mantissa.
      w_rsh    = 5'(9'sd23 - i_exp);
      w_ext    = {i_sig, 24'b0} >> w_rsh;
      o_int    = {8'b0, w_ext[47:24]};
      o_guard  = w_ext[23];
      o_sticky = |w_ext[22:0];
    end
  end

endmodule

// File: rtl/fpu_f2i.sv
// rtl/fpu_f2i.sv - pipelined IEEE754 single to signed 32-bit integer converter
module fpu_f2i
  import fpu_pkg::*;
#(
  parameter int BIAS        = fpu_pkg::BIAS,
  parameter int RNE_DEFAULT = 1
) (
  input  logic        FPUCLK,
  input  logic        RSTN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] A,
  input  logic        ROUND,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT,
  output logic [1:0]  FLAGS
);

  if (RNE_DEFAULT != 0 && RNE_DEFAULT != 1) begin : g_rne_check
    $error("fpu_f2i: RNE_DEFAULT must be 0 or 1");
  end

  logic              w_adv;
  logic              r0_valid, r1_valid, r2_valid, r3_valid;
  logic [31:0]       r0_a;
  logic              r0_round;
  f2i_s1_t           r1;
  f2i_s1_t           w_s1;
  logic [7:0]        w_exp;
  logic [22:0]       w_mant;
  logic signed [8:0] w_e;

  logic [31:0] w_int;
  logic        w_guard, w_sticky, w_ovf, w_min;
  logic        r2_sign, r2_rnd, r2_nz, r2_guard, r2_sticky, r2_ovf, r2_min;
  logic [2:0]  r2_cls;
  logic [31:0] r2_int;

  logic        w_inc;
  logic [32:0] w_sum;
  logic [31:0] w_sat, w_res;
  logic [1:0]  w_flg;
  logic [31:0] r_out;
  logic [1:0]  r_flags;

  assign w_adv     = !r3_valid || OUT_READY;
  assign IN_READY  = w_adv;
  assign OUT_VALID = r3_valid;
  assign OUT       = r_out;
  assign FLAGS     = r_flags;

  // Stage 1: unpack and classify the captured operand.
  assign w_exp  = r0_a[EXP_HI:EXP_LO];
  assign w_mant = r0_a[MANT_W-1:0];
  assign w_e    = $signed({1'b0, w_exp}) - $signed(9'(BIAS));

  always_comb begin
    w_s1.sign = r0_a[SIGN_B];
    w_s1.rnd  = r0_round;
    w_s1.e    = w_e;
    w_s1.sig  = {|w_exp, w_mant};
    w_s1.cls  = CLS_NORM;
    if (w_exp == 8'hFF) begin
      w_s1.cls = (w_mant != '0) ? CLS_NAN : CLS_INF;
    end else if (w_exp == 8'h00) begin
      w_s1.cls = CLS_ZERO;
    end else if (w_e < -9'sd1) begin
      w_s1.cls = CLS_TINY;
    end
  end

  // Stage 2: align.
  f2i_align u_align (
    .i_sig    (r1.sig),
    .i_exp    ($signed(r1.e)),
    .o_int    (w_int),
    .o_guard  (w_guard),
    .o_sticky (w_sticky),
    .o_ovf    (w_ovf),
    .o_min    (w_min)
  );

  // Stage 3: round, apply sign, saturate.
  always_comb begin
    w_inc = r2_rnd & r2_guard & (r2_sticky | r2_int[0]);
    w_sum = {1'b0, r2_int} + {32'b0, w_inc};
    w_sat = r2_sign ? INT_MIN : INT_MAX;
    w_res = '0;
    w_flg = 2'b00;
    case (r2_cls)
      CLS_NAN: begin
        w_res = INT_MAX;
        w_flg = 2'b10;
      end
      CLS_INF: begin
        w_res = w_sat;
        w_flg = 2'b10;
      end
      CLS_ZERO: w_flg = {1'b0, r2_nz};
      CLS_TINY: w_flg = 2'b01;
      default: begin
        if (r2_min && r2_sign) begin
          w_res = INT_MIN;
        end else if (r2_ovf || (w_sum[32:31] != 2'b00)) begin
          w_res = w_sat;
          w_flg = 2'b10;
        end else begin
          w_res = r2_sign ? (32'd0 - w_sum[31:0]) : w_sum[31:0];
          w_flg = {1'b0, r2_guard | r2_sticky};
        end
      end
    endcase
  end

  always_ff @(posedge FPUCLK) begin
    if (w_adv) begin
      r0_a      <= A;
      r0_round  <= ROUND;
      r1        <= w_s1;
      r2_sign   <= r1.sign;
      r2_rnd    <= r1.rnd;
      r2_cls    <= r1.cls;
      r2_nz     <= |r1.sig[22:0];
      r2_int    <= w_int;
      r2_guard  <= w_guard;
      r2_sticky <= w_sticky;
      r2_ovf    <= w_ovf;
      r2_min    <= w_min;
    end
  end

  always_ff @(posedge FPUCLK or negedge RSTN) begin
    if (!RSTN) begin
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
      r_out    <= '0;
      r_flags  <= '0;
    end else if (w_adv) begin
      r0_valid <= IN_VALID;
      r1_valid <= r0_valid;
      r2_valid <= r1_valid;
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r_out   <= w_res;
        r_flags <= w_flg;
      end
    end
  end

endmodule
